// File: rtl/frog_pkg.sv
// Shared types and constants for the frog movement/collision controller.
package frog_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_RIGHT = 3;

  localparam logic [3:0] BTN_NONE = 4'b0000;
  localparam logic [3:0] BTN_ALL  = 4'b1111;

  localparam int CAR_LEN_W = 3;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/frog_hit_detect.sv
// Combinational frog-vs-car overlap test, OR-reduced across all car channels.
module frog_hit_detect
  import frog_pkg::*;
#(
  parameter int NUM_CARS = 11,
  parameter int COL_W    = 5,
  parameter int ROW_W    = 4
) (
  input  logic [NUM_CARS*COL_W-1:0]     car_x,
  input  logic [NUM_CARS*ROW_W-1:0]     car_y,
  input  logic [NUM_CARS*CAR_LEN_W-1:0] car_len,
  input  logic [COL_W-1:0]              frog_col,
  input  logic [ROW_W-1:0]              frog_row,
  output logic                          hit
);

  logic [NUM_CARS-1:0] car_hit;

  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    logic [COL_W-1:0]     x;
    logic [ROW_W-1:0]     y;
    logic [CAR_LEN_W-1:0] len;
    logic [COL_W:0]       x_end;

    assign x   = car_x[i*COL_W +: COL_W];
    assign y   = car_y[i*ROW_W +: ROW_W];
    assign len = car_len[i*CAR_LEN_W +: CAR_LEN_W];
    // One extra bit keeps cars hanging past the last column from wrapping to column 0.
    assign x_end = {1'b0, x} + (COL_W+1)'(len);

    assign car_hit[i] = (len != '0) && (y == frog_row) &&
                        (frog_col >= x) && ({1'b0, frog_col} < x_end);
  end

  assign hit = |car_hit;

endmodule

// File: rtl/frog_controller.sv
// Frog position, lives, level and respawn FSM; collision test is delegated to frog_hit_detect.
module frog_controller
  import frog_pkg::*;
#(
  parameter int GRID_COLS  = 20,
  parameter int GRID_ROWS  = 15,
  parameter int NUM_CARS   = 11,
  parameter int LIVES      = 3,
  parameter int HIT_CYCLES = 25_000_000,
  localparam int COL_W     = $clog2(GRID_COLS),
  localparam int ROW_W     = $clog2(GRID_ROWS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    btn,
  input  logic [NUM_CARS*COL_W-1:0]     car_x,
  input  logic [NUM_CARS*ROW_W-1:0]     car_y,
  input  logic [NUM_CARS*CAR_LEN_W-1:0] car_len,
  output logic [COL_W-1:0]              frog_col,
  output logic [ROW_W-1:0]              frog_row,
  output logic [2:0]                    lives,
  output logic [3:0]                    level,
  output logic                          hit_pulse,
  output logic                          level_pulse,
  output logic                          game_over,
  output logic                          frog_visible
);

  localparam int CNT_W = $clog2(HIT_CYCLES + 1);

  localparam logic [COL_W-1:0] START_COL  = COL_W'(GRID_COLS / 2);
  localparam logic [ROW_W-1:0] START_ROW  = ROW_W'(GRID_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(GRID_COLS - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HIT_CYCLES - 1);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [2:0]       lives_q, lives_d;
  logic [3:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             level_pulse_q, level_pulse_d;
  logic             game_over_q, game_over_d;
  logic             visible_q, visible_d;

  logic             hit;
  logic             mv_ok;
  logic [COL_W-1:0] mv_col;
  logic [ROW_W-1:0] mv_row;

  frog_hit_detect #(
    .NUM_CARS (NUM_CARS),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_hit (
    .car_x    (car_x),
    .car_y    (car_y),
    .car_len  (car_len),
    .frog_col (col_q),
    .frog_row (row_q),
    .hit      (hit)
  );

  // Highest-priority pressed direction and whether that step stays on the grid.
  always_comb begin
    mv_ok  = 1'b0;
    mv_col = col_q;
    mv_row = row_q;
    if (btn[BTN_LEFT]) begin
      mv_ok  = (col_q != '0);
      mv_col = col_q - 1'b1;
    end else if (btn[BTN_DOWN]) begin
      mv_ok  = (row_q != START_ROW);
      mv_row = row_q + 1'b1;
    end else if (btn[BTN_UP]) begin
      mv_ok  = (row_q != '0);
      mv_row = row_q - 1'b1;
    end else if (btn[BTN_RIGHT]) begin
      mv_ok  = (col_q != LAST_COL);
      mv_col = col_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    lives_d       = lives_q;
    level_d       = level_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q | (btn == BTN_NONE);
    hit_pulse_d   = 1'b0;
    level_pulse_d = 1'b0;

    case (state_q)
      PLAY: begin
        if (hit) begin
          state_d     = HIT;
          lives_d     = lives_q - 3'd1;
          col_d       = START_COL;
          row_d       = START_ROW;
          cnt_d       = HOLD_LOAD;
          hit_pulse_d = 1'b1;
        end else if (row_q == '0) begin
          level_d       = sat_inc4(level_q);
          level_pulse_d = 1'b1;
          col_d         = START_COL;
          row_d         = START_ROW;
        end else if (armed_q && btn == BTN_ALL) begin
          col_d   = START_COL;
          row_d   = START_ROW;
          armed_d = 1'b0;
        end else if (armed_q && mv_ok) begin
          col_d   = mv_col;
          row_d   = mv_row;
          armed_d = 1'b0;
        end
      end
      HIT: begin
        if (cnt_q == '0) state_d = (lives_q == '0) ? OVER : PLAY;
        else             cnt_d   = cnt_q - 1'b1;
      end
      OVER: begin
        if (btn == BTN_ALL) begin
          state_d = PLAY;
          lives_d = LIVES_INIT;
          level_d = '0;
          armed_d = 1'b0;
        end
      end
      default: state_d = PLAY;
    endcase

    game_over_d = (state_d == OVER);
    visible_d   = (state_d != HIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PLAY;
      col_q         <= START_COL;
      row_q         <= START_ROW;
      lives_q       <= LIVES_INIT;
      level_q       <= '0;
      cnt_q         <= '0;
      armed_q       <= 1'b1;
      hit_pulse_q   <= 1'b0;
      level_pulse_q <= 1'b0;
      game_over_q   <= 1'b0;
      visible_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      hit_pulse_q   <= hit_pulse_d;
      level_pulse_q <= level_pulse_d;
      game_over_q   <= game_over_d;
      visible_q     <= visible_d;
    end
  end

  assign frog_col     = col_q;
  assign frog_row     = row_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign hit_pulse    = hit_pulse_q;
  assign level_pulse  = level_pulse_q;
  assign game_over    = game_over_q;
  assign frog_visible = visible_q;

endmodule

// File: doc/frog_controller.md
# frog_controller

Parametrised successor to the frog movement/collision block. It holds the frog position on a configurable grid and moves it one cell per debounced button press. It tests the frog against NUM_CARS variable-length cars and manages lives, a post-hit respawn window, level advance on reaching the top row, and game-over. It sits between the button debouncers and the car generators on one side and the VGA renderer and score/HUD logic on the other.

## Interface
Parameters:
- GRID_COLS, 20, grid width in cells; COL_W = $clog2(GRID_COLS)
- GRID_ROWS, 15, grid height in cells; ROW_W = $clog2(GRID_ROWS)
- NUM_CARS, 11, number of car channels
- LIVES, 3, lives at reset/restart (1..7)
- HIT_CYCLES, 25_000_000, respawn hold after a hit (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock domain
- btn  in  4  debounced buttons; bit0 left, bit1 down, bit2 up, bit3 right
- car_x  in  NUM_CARS*COL_W  packed car left columns; car i at [i*COL_W +: COL_W]
- car_y  in  NUM_CARS*ROW_W  packed car rows
- car_len  in  NUM_CARS*3  car lengths in cells; 0 = car disabled
- frog_col  out  COL_W  frog column
- frog_row  out  ROW_W  frog row
- lives  out  3  remaining lives
- level  out  4  levels completed, saturates at 15
- hit_pulse  out  1  one-cycle pulse on collision
- level_pulse  out  1  one-cycle pulse on reaching row 0
- game_over  out  1  high while in OVER state
- frog_visible  out  1  low during HIT hold (renderer blanks/flashes frog)

## Operation
- Start cell: col GRID_COLS/2, row GRID_ROWS-1.
- Reset values: frog at start cell, lives=LIVES, level=0, state PLAY, armed=1, pulses 0, game_over=0, frog_visible=1.
- Move arming: one move per press. A move clears `armed`. `armed` sets again only in a cycle where btn==4'b0000.
- States:
  - PLAY: if armed, exactly one button bit set, and the move stays on the grid, move one cell and clear armed. A press that would leave the grid is ignored, but armed stays set. With two or three bits set, priority is left > down > up > right, again one move. btn==4'b1111 returns the frog to the start cell with no life lost and clears armed.
  - PLAY → HIT: a collision on the registered position. Lives decrement, frog goes to the start cell, hit_pulse fires, the hold counter loads HIT_CYCLES-1.
  - PLAY → PLAY (win): frog_row==0 with no collision. level increments (saturating), level_pulse fires, frog goes to the start cell.
  - HIT: movement and collision are ignored and frog_visible=0. When the counter reaches 0, go to PLAY, or to OVER if lives==0.
  - OVER: game_over=1 and the frog is frozen at the start cell. btn==4'b1111 restarts: lives=LIVES, level=0, go to PLAY, armed cleared.
- Collision for car i: car_len≠0, car_y==frog_row, and car_x ≤ frog_col < car_x+car_len. The sum is computed COL_W+1 bits wide, so no wrap; cells past the grid edge never match.
- Simultaneous events: collision beats win and beats a move in the same cycle. A move decision and a collision never both apply.
- reset mid-HIT or mid-OVER returns immediately to the reset values.

## Timing
- Move: registered 1 cycle after the first cycle btn is valid while armed.
- Collision: evaluated combinationally on the registered frog and car inputs. State, lives and hit_pulse update on the next edge.
- HIT lasts exactly HIT_CYCLES cycles, then 1 cycle to reach PLAY/OVER.
- level_pulse and hit_pulse are each high for exactly one cycle.
- Car inputs are sampled every cycle and need no handshake. The car generators are on the same clk.

## Structure
- Package frog_pkg:
  - state enum {PLAY, HIT, OVER}
  - button bit index constants BTN_LEFT/DOWN/UP/RIGHT
  - CAR_LEN_W=3
- Sub-module frog_hit_detect: parametrised by NUM_CARS, COL_W, ROW_W. Purely combinational OR-reduction over the cars; outputs `hit`.
- Top: FSM, hold counter, position, lives and level registers.

## Test plan
- Reset, then single presses: left ×3 with a release between each → frog_col 10→7. Holding left for 100 cycles → exactly one move. left+up together → left only.
- Edge clamp: at col 0, press left → col stays 0. Release, press right → col 1.
- Collision: car0 x=5, y=13, len=4, frog moved to (8,13) → hit_pulse one cycle, lives 3→2, frog (10,14), frog_visible=0 for HIT_CYCLES (set 8 in bench), then PLAY. A frog at (9,13) → no hit. car_len=0 → no hit.
- Win: walk the frog to row 0 with no cars → level_pulse, level=1, frog at start. Repeat 16× → level saturates at 15.
- Game over: three hits → game_over=1 after the third hold. Buttons ignored. btn=1111 → lives=3, level=0, PLAY.
- Simultaneous: a collision on the same cycle as row 0 or a press → hit path only, level unchanged. reset asserted during HIT → reset values next cycle.
